// File: rtl/text_writer.sv
// Character-stream writer: cursor tracking, control codes and screen clear for the text-mode buffer.
// Optional per-row clear on every row change: define TEXT_WRITER_CLEAR_LINE_EN.
`ifndef FONT_WIDTH
`define FONT_WIDTH 8
`endif

module text_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int ADDR_W = 13
) (
  input  logic                      px_clk,
  input  logic                      rst_n,
  input  logic [`FONT_WIDTH-1:0]    in_char,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [`FONT_WIDTH-1:0]    wr_data,
  output logic [$clog2(COLS)-1:0]   cur_x,
  output logic [$clog2(ROWS)-1:0]   cur_y
);
  localparam int FW    = `FONT_WIDTH;
  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);
  localparam int CELLS = COLS * ROWS;

  localparam logic [FW-1:0] C_SP = FW'(32'h20);
  localparam logic [FW-1:0] C_FF = FW'(32'h0C);
  localparam logic [FW-1:0] C_CR = FW'(32'h0D);
  localparam logic [FW-1:0] C_LF = FW'(32'h0A);
  localparam logic [FW-1:0] C_BS = FW'(32'h08);

`ifdef TEXT_WRITER_CLEAR_LINE_EN
  typedef enum logic [1:0] {IDLE, CLR_SCR, CLR_LINE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLR_SCR} state_t;
`endif

  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [FW-1:0]     r_wr_data;

  logic [ADDR_W-1:0] w_row_base;
  logic [ADDR_W-1:0] w_addr;
  logic [YW-1:0]     w_ny;
  logic              w_acc;

  assign w_row_base = ADDR_W'(r_y) * ADDR_W'(COLS);
  assign w_addr     = w_row_base + ADDR_W'(r_x);
  assign w_ny       = (r_y == YW'(ROWS - 1)) ? '0 : r_y + 1'b1;
  assign w_acc      = in_valid && (r_state == IDLE);

  assign in_ready = (r_state == IDLE);
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cur_x    = r_x;
  assign cur_y    = r_y;

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLR_SCR;
      r_cnt     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: if (w_acc) begin
          case (in_char)
            C_FF: begin
              r_state <= CLR_SCR;
              r_cnt   <= '0;
            end
            C_CR: r_x <= '0;
            C_LF: begin
              r_x <= '0;
              r_y <= w_ny;
`ifdef TEXT_WRITER_CLEAR_LINE_EN
              r_state <= CLR_LINE;
              r_cnt   <= '0;
`endif
            end
            C_BS: if (r_x != '0) begin
              r_x       <= r_x - 1'b1;
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_addr - 1'b1;
              r_wr_data <= C_SP;
            end
            default: begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_addr;
              r_wr_data <= in_char;
              if (r_x == XW'(COLS - 1)) begin
                r_x <= '0;
                r_y <= w_ny;
`ifdef TEXT_WRITER_CLEAR_LINE_EN
                r_state <= CLR_LINE;
                r_cnt   <= '0;
`endif
              end else begin
                r_x <= r_x + 1'b1;
              end
            end
          endcase
        end
        // One spare cycle after the last write so in_ready rises after the final clear strobe.
        CLR_SCR: begin
          if (r_cnt == (ADDR_W+1)'(CELLS)) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_cnt[ADDR_W-1:0];
            r_wr_data <= C_SP;
            r_cnt     <= r_cnt + 1'b1;
          end
        end
`ifdef TEXT_WRITER_CLEAR_LINE_EN
        CLR_LINE: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_row_base + r_cnt[ADDR_W-1:0];
          r_wr_data <= C_SP;
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == (ADDR_W+1)'(COLS - 1)) begin
            r_state <= IDLE;
            r_x     <= '0;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer in its default build (no per-row clear).
module tb_text_writer;
  logic        px_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [7:0]  in_char = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cur_x;
  logic [5:0]  cur_y;

  int total = 0;
  int bad   = 0;

  text_writer #(.COLS(80), .ROWS(60), .ADDR_W(13)) dut (
    .px_clk(px_clk), .rst_n(rst_n), .in_char(in_char), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 px_clk = ~px_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    in_char  = c;
    in_valid = 1'b1;
    @(negedge px_clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_char  = '0;
    @(negedge px_clk);
  endtask

  // Follows a clear; returns after the write at stop_at, or after the first idle cycle following writes.
  task automatic watch_clear(input int stop_at, output int n, output bit ok);
    n  = 0;
    ok = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge px_clk);
      if (wr_en) begin
        if (wr_addr !== 13'(n) || wr_data !== 8'h20 || in_ready !== 1'b0) ok = 1'b0;
        n++;
        if (n - 1 == stop_at) return;
      end else if (n > 0) begin
        return;
      end
    end
  endtask

  initial begin
    int n;
    bit ok;

    @(negedge px_clk);
    @(negedge px_clk);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_addr",  32'(wr_addr), 0);
    chk("rst_data",  32'(wr_data), 0);
    chk("rst_cur",   {cur_y, cur_x}, 0);

    rst_n = 1'b1;
    watch_clear(-1, n, ok);
    chk("clr_count", n, 4800);
    chk("clr_seq",   32'(ok), 1);
    chk("clr_ready", 32'(in_ready), 1);
    chk("clr_wr_off", 32'(wr_en), 0);
    chk("clr_cur",   {cur_y, cur_x}, 0);

    send(8'h41);
    chk("A_wr",    {wr_en, wr_addr, wr_data}, {1'b1, 13'd0, 8'h41});
    chk("A_ready", 32'(in_ready), 1);
    send(8'h42);
    chk("B_wr",    {wr_en, wr_addr, wr_data}, {1'b1, 13'd1, 8'h42});
    chk("B_ready", 32'(in_ready), 1);
    chk("B_cur_x", 32'(cur_x), 2);
    idle();
    chk("idle_wr", 32'(wr_en), 0);

    send(8'h0D);
    chk("cr_wr",  32'(wr_en), 0);
    chk("cr_cur", {cur_y, cur_x}, 0);

    ok = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send(8'h41);
      if (!wr_en || wr_addr !== 13'(i) || wr_data !== 8'h41 || !in_ready) ok = 1'b0;
    end
    chk("row_seq",  32'(ok), 1);
    chk("row_last", 32'(wr_addr), 79);
    chk("row_cur",  {cur_y, cur_x}, {6'd1, 7'd0});
    idle();
    chk("row_noclr", 32'(wr_en), 0);
    chk("row_ready", 32'(in_ready), 1);

    ok = 1'b1;
    for (int i = 0; i < 58; i++) begin
      send(8'h0A);
      if (wr_en || !in_ready) ok = 1'b0;
    end
    chk("lf_seq",  32'(ok), 1);
    chk("lf_cur",  {cur_y, cur_x}, {6'd59, 7'd0});
    send(8'h0A);
    chk("lf_wrap_cur", {cur_y, cur_x}, 0);
    chk("lf_wrap_wr",  32'(wr_en), 0);
    chk("lf_wrap_rdy", 32'(in_ready), 1);

    send(8'h41);
    chk("bsA", {wr_en, wr_addr, wr_data}, {1'b1, 13'd0, 8'h41});
    send(8'h42);
    chk("bsB", {wr_en, wr_addr, wr_data}, {1'b1, 13'd1, 8'h42});
    send(8'h08);
    chk("bs1", {wr_en, wr_addr, wr_data}, {1'b1, 13'd1, 8'h20});
    chk("bs1_x", 32'(cur_x), 1);
    send(8'h08);
    chk("bs2", {wr_en, wr_addr, wr_data}, {1'b1, 13'd0, 8'h20});
    chk("bs2_x", 32'(cur_x), 0);
    send(8'h08);
    chk("bs3_wr", 32'(wr_en), 0);
    chk("bs3_x",  32'(cur_x), 0);

    send(8'h01);
    chk("ctl_verbatim", {wr_en, wr_addr, wr_data}, {1'b1, 13'd0, 8'h01});
    send(8'h0A);
    send(8'h43);
    chk("row1_addr", {wr_en, wr_addr, wr_data}, {1'b1, 13'd80, 8'h43});
    chk("row1_cur",  {cur_y, cur_x}, {6'd1, 7'd1});

    send(8'h0C);
    in_valid = 1'b0;
    chk("ff_wr",    32'(wr_en), 0);
    chk("ff_ready", 32'(in_ready), 0);
    watch_clear(1000, n, ok);
    chk("ff_partial", n, 1001);
    chk("ff_seq", 32'(ok), 1);

    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 0);
    chk("arst_addr",  32'(wr_addr), 0);
    chk("arst_ready", 32'(in_ready), 0);
    chk("arst_cur",   {cur_y, cur_x}, 0);
    @(negedge px_clk);
    rst_n = 1'b1;
    watch_clear(-1, n, ok);
    chk("reclr_count", n, 4800);
    chk("reclr_seq",   32'(ok), 1);
    chk("reclr_ready", 32'(in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
